// File: rtl/tc_clk_pkg.sv
// Shared types and constants for the timer clock-enable generator.
package tc_clk_pkg;

    localparam int unsigned PRESC_W     = 10;
    localparam int unsigned CS_W        = 3;
    localparam int unsigned TAP8_EXP    = 3;
    localparam int unsigned TAP64_EXP   = 6;
    localparam int unsigned TAP256_EXP  = 8;
    localparam int unsigned TAP1024_EXP = 10;

    typedef enum logic [CS_W-1:0] {
        CS_STOP    = 3'b000,
        CS_CLK     = 3'b001,
        CS_DIV8    = 3'b010,
        CS_DIV64   = 3'b011,
        CS_DIV256  = 3'b100,
        CS_DIV1024 = 3'b101,
        CS_TN_FALL = 3'b110,
        CS_TN_RISE = 3'b111
    } cs_e;

    // True when the low 'e' bits of the prescaler are all ones.
    function automatic logic tap_hit(input logic [PRESC_W-1:0] cnt, input int unsigned e);
        logic [PRESC_W-1:0] mask;
        mask = PRESC_W'((32'd1 << e) - 32'd1);
        return (cnt & mask) == mask;
    endfunction

endpackage

// File: rtl/tn_edge_filter.sv
// One Tn pin: synchroniser, optional majority-free noise filter, edge detect.
module tn_edge_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tn,
    input  logic tnf_en,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned HIST_W = FILT_LEN - 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [HIST_W-1:0]      hist_q;
    logic [FILT_LEN-1:0]    window;
    logic                   synced;
    logic                   filt_q;
    logic                   level;
    logic                   prev_q;

    assign synced = sync_q[SYNC_STAGES-1];
    // Window includes the live synced sample so the filter adds exactly FILT_LEN cycles.
    assign window = {hist_q, synced};
    assign level  = tnf_en ? filt_q : synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
            filt_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, tn});
            hist_q <= HIST_W'({hist_q, synced});
            if (&window) begin
                filt_q <= 1'b1;
            end else if (~|window) begin
                filt_q <= 1'b0;
            end
            prev_q <= level;
        end
    end

    assign rise_c = ~prev_q & level;
    assign fall_c = prev_q & ~level;

endmodule

// File: rtl/tc_clk_prescale_sel.sv
// Shared prescaler plus per-channel clock-enable select for the timer cores.
module tc_clk_prescale_sel
    import tc_clk_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 psrsync,
    input  logic                 tsm,
    input  logic [N_CH-1:0]      tn_in,
    input  logic [N_CH-1:0]      tnf_en,
    input  logic [CS_W*N_CH-1:0] cs,
    output logic [N_CH-1:0]      clk_en,
    output logic                 psr_clr
);

    logic [PRESC_W-1:0] pcnt;
    logic               tap8;
    logic               tap64;
    logic               tap256;
    logic               tap1024;
    logic               halt;

    // A pending PSRSYNC loads zero; under TSM the request stays set, holding pcnt at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            psr_clr <= 1'b0;
        end else begin
            pcnt    <= psrsync ? '0 : pcnt + PRESC_W'(1);
            psr_clr <= psrsync & ~tsm;
        end
    end

    assign tap8    = tap_hit(pcnt, TAP8_EXP);
    assign tap64   = tap_hit(pcnt, TAP64_EXP);
    assign tap256  = tap_hit(pcnt, TAP256_EXP);
    assign tap1024 = tap_hit(pcnt, TAP1024_EXP);
    assign halt    = tsm & psrsync;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic rise_c;
        logic fall_c;
        logic sel_en;
        cs_e  sel;

        tn_edge_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_tn (
            .clk   (clk),
            .rst_n (rst_n),
            .tn    (tn_in[i]),
            .tnf_en(tnf_en[i]),
            .rise_c(rise_c),
            .fall_c(fall_c)
        );

        assign sel = cs_e'(cs[CS_W*i +: CS_W]);

        always_comb begin
            sel_en = 1'b0;
            case (sel)
                CS_STOP:    sel_en = 1'b0;
                CS_CLK:     sel_en = 1'b1;
                CS_DIV8:    sel_en = tap8;
                CS_DIV64:   sel_en = tap64;
                CS_DIV256:  sel_en = tap256;
                CS_DIV1024: sel_en = tap1024;
                CS_TN_FALL: sel_en = fall_c;
                CS_TN_RISE: sel_en = rise_c;
                default:    sel_en = 1'b0;
            endcase
        end

        assign clk_en[i] = sel_en & ~halt;
    end

endmodule
